uart_rx_byte: RTL

- 8N1 UART receiver producing the byte stream for the UART-to-BRAM async FIFO write port. Lives entirely in the 100 MHz i_clk_wr domain.
- o_valid_uart / o_data_uart connect directly to the FIFO's i_valid_uart / i_data_uart.
- Oversamples a raw asynchronous RX pin with a baud counter and a frame state machine. Emits one single-cycle valid pulse per correctly framed byte.

---
 rtl/uart_rx_byte.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver; optional parity bit when UART_RX_PARITY_EN is defined
module uart_rx_byte #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       i_clk_wr,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data_uart,
  output logic       o_valid_uart,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int          DIV       = CLK_FREQ / BAUD_RATE;
  localparam int          HALF      = DIV / 2;
  localparam logic [15:0] FULL_LAST = 16'(DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_n;
  logic        valid_n;
  logic        ferr_n;
  logic        rx_meta;
  logic        rx_s;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic perr_flag, perr_flag_n;
  logic perr_pulse_n;
`endif

  // Two-flop synchronizer on the raw line; idles high so reset looks like an idle line
  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered output pulses
  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      o_data_uart  <= 8'h00;
      o_valid_uart <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_flag    <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      shreg        <= shreg_n;
      o_data_uart  <= data_n;
      o_valid_uart <= valid_n;
      o_frame_err  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      perr_flag    <= perr_flag_n;
      o_parity_err <= perr_pulse_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

  assign o_busy = (state != S_IDLE);

  // Frame sequencing: counter runs while waiting for a sample point and clears on every sample
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    data_n  = o_data_uart;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_flag_n  = perr_flag;
    perr_pulse_n = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = S_START;
`ifdef UART_RX_PARITY_EN
          perr_flag_n = 1'b0;
`endif
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          // A start bit that is high again at its midpoint was only a glitch
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_n       = '0;
          perr_flag_n = (rx_s != ((^shreg) ^ PAR_SENSE));
          state_n     = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            // Leave at mid stop bit so a back-to-back start edge is seen in time
            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (perr_flag) begin
              perr_pulse_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              data_n  = shreg;
            end
`else
            valid_n = 1'b1;
            data_n  = shreg;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot retrigger
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
